cam_subarray_ctrl: RTL and testbench

//  Command sequencer in front of one CAM subarray (32 cmp rows + 4 ppg rows, 16-bit words).

---
 rtl/cam_subarray_ctrl_if.sv | 31 +++
 rtl/cam_subarray_ctrl.sv | 149 ++++++++++++++
 tb/tb_cam_subarray_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_subarray_ctrl_if.sv
// Command/response handshake bundle between a requester and the CAM subarray controller.
interface cam_subarray_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic        cmd_addr_sel;
    logic [9:0]  cmd_cmp_addr;
    logic [3:0]  cmd_ppg_addr;
    logic [1:0]  cmd_cmp_data;
    logic [1:0]  cmd_ppg_data;
    logic [15:0] cmd_data;
    logic [15:0] cmd_tag;
    logic        cmd_update;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_tag;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr_sel, cmd_cmp_addr, cmd_ppg_addr,
               cmd_cmp_data, cmd_ppg_data, cmd_data, cmd_tag, cmd_update, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tag, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_sel, cmd_cmp_addr, cmd_ppg_addr,
               cmd_cmp_data, cmd_ppg_data, cmd_data, cmd_tag, cmd_update, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tag, rsp_err
    );
endinterface

// File: rtl/cam_subarray_ctrl.sv
// CAM subarray command sequencer: one command in flight, a single chip_enable pulse per
// command, write_done timeout and a saturating error counter.
module cam_subarray_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 4,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    cam_subarray_ctrl_if.slave       bus_io,
    output logic [15:0]              sub_data_in_o,
    output logic                     sub_update_signal_o,
    output logic [9:0]               sub_cmp_addr_o,
    output logic [3:0]               sub_ppg_addr_o,
    output logic [1:0]               sub_cmp_data_o,
    output logic [1:0]               sub_ppg_data_o,
    output logic [15:0]              sub_tag_in_o,
    output logic                     sub_addr_select_o,
    output logic [2:0]               sub_operation_mode_o,
    output logic                     sub_chip_enable_o,
    input  logic [15:0]              sub_tag_out_i,
    input  logic                     sub_write_done_i,
    output logic                     busy_o,
    output logic [ERR_CNT_W-1:0]     err_cnt_o
);
    localparam int unsigned    ToW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ToW-1:0] ToLast    = ToW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]     OpIllegal = 3'b111;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    typedef struct packed {
        logic [15:0] data;
        logic        update;
        logic [9:0]  cmp_addr;
        logic [3:0]  ppg_addr;
        logic [1:0]  cmp_data;
        logic [1:0]  ppg_data;
        logic [15:0] tag;
        logic        addr_sel;
        logic [2:0]  op;
    } sub_t;

    state_e               state_q, state_d;
    sub_t                 sub_q, sub_d;
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;
    logic [15:0]          rsp_tag_q, rsp_tag_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 enter_err;
    logic                 is_write;

    assign is_write = (sub_q.op[2:1] == 2'b00);

    always_comb begin
        state_d   = state_q;
        sub_d     = sub_q;
        to_cnt_d  = to_cnt_q;
        rsp_tag_d = rsp_tag_q;
        rsp_err_d = rsp_err_q;
        err_cnt_d = err_cnt_q;
        enter_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.cmd_valid) begin
                    sub_d = '{data:     bus_io.cmd_data,
                              update:   bus_io.cmd_update,
                              cmp_addr: bus_io.cmd_cmp_addr,
                              ppg_addr: bus_io.cmd_ppg_addr,
                              cmp_data: bus_io.cmd_cmp_data,
                              ppg_data: bus_io.cmd_ppg_data,
                              tag:      bus_io.cmd_tag,
                              addr_sel: bus_io.cmd_addr_sel,
                              op:       bus_io.cmd_op};
                    if (bus_io.cmd_op == OpIllegal) begin
                        state_d   = StResp;
                        rsp_tag_d = '0;
                        rsp_err_d = 1'b1;
                        enter_err = 1'b1;
                    end else begin
                        state_d  = StIssue;
                        to_cnt_d = '0;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (!is_write) begin
                    state_d   = StResp;
                    rsp_tag_d = sub_tag_out_i;
                    rsp_err_d = 1'b0;
                end else if (sub_write_done_i) begin
                    // done wins over a coincident final timeout step
                    state_d   = StResp;
                    rsp_tag_d = '0;
                    rsp_err_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == ToLast) begin
                        state_d   = StResp;
                        rsp_tag_d = '0;
                        rsp_err_d = 1'b1;
                        enter_err = 1'b1;
                    end
                end
            end
            StResp: begin
                if (bus_io.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (enter_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            sub_q     <= '0;
            to_cnt_q  <= '0;
            rsp_tag_q <= '0;
            rsp_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            to_cnt_q  <= to_cnt_d;
            rsp_tag_q <= rsp_tag_d;
            rsp_err_q <= rsp_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus_io.cmd_ready = (state_q == StIdle);
    assign bus_io.rsp_valid = (state_q == StResp);
    assign bus_io.rsp_tag   = rsp_tag_q;
    assign bus_io.rsp_err   = rsp_err_q;
    assign busy_o           = (state_q != StIdle);
    assign err_cnt_o        = err_cnt_q;

    assign sub_data_in_o        = sub_q.data;
    assign sub_update_signal_o  = sub_q.update;
    assign sub_cmp_addr_o       = sub_q.cmp_addr;
    assign sub_ppg_addr_o       = sub_q.ppg_addr;
    assign sub_cmp_data_o       = sub_q.cmp_data;
    assign sub_ppg_data_o       = sub_q.ppg_data;
    assign sub_tag_in_o         = sub_q.tag;
    assign sub_addr_select_o    = sub_q.addr_sel;
    assign sub_operation_mode_o = sub_q.op;
    assign sub_chip_enable_o    = (state_q == StIssue);
endmodule

// File: tb/tb_cam_subarray_ctrl.sv
// Randomized bench for cam_subarray_ctrl: a toy subarray plus a cycle-timeline reference model.
module tb_cam_subarray_ctrl;
    localparam int TO = 4;

    typedef struct packed {
        logic [2:0]  op;
        logic        sel;
        logic [9:0]  ca;
        logic [3:0]  pa;
        logic [1:0]  cd;
        logic [1:0]  pd;
        logic [15:0] d;
        logic [15:0] t;
        logic        u;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_subarray_ctrl_if bus ();

    logic [15:0] sub_data, sub_tag, sub_tag_out;
    logic        sub_upd, sub_sel, sub_ce;
    logic [9:0]  sub_ca;
    logic [3:0]  sub_pa;
    logic [1:0]  sub_cd, sub_pd;
    logic [2:0]  sub_op;
    logic        sub_write_done = 1'b0;
    logic        busy;
    logic [7:0]  err_cnt;

    cam_subarray_ctrl #(.TIMEOUT_CYC(TO), .ERR_CNT_W(8)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .bus_io               (bus),
        .sub_data_in_o        (sub_data),
        .sub_update_signal_o  (sub_upd),
        .sub_cmp_addr_o       (sub_ca),
        .sub_ppg_addr_o       (sub_pa),
        .sub_cmp_data_o       (sub_cd),
        .sub_ppg_data_o       (sub_pd),
        .sub_tag_in_o         (sub_tag),
        .sub_addr_select_o    (sub_sel),
        .sub_operation_mode_o (sub_op),
        .sub_chip_enable_o    (sub_ce),
        .sub_tag_out_i        (sub_tag_out),
        .sub_write_done_i     (sub_write_done),
        .busy_o               (busy),
        .err_cnt_o            (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] srch(input logic [2:0] op, input logic [15:0] crow,
                                         input logic [15:0] prow, input logic [1:0] cd,
                                         input logic [1:0] pd);
        logic [15:0] v;
        logic key;
        case (op)
            3'b010:  begin v = crow;        key = cd[0];         end
            3'b011:  begin v = prow;        key = pd[0];         end
            default: begin v = crow ^ prow; key = cd[0] ^ pd[0]; end
        endcase
        return key ? v : ~v;
    endfunction

    function automatic logic [15:0] upd_row(input logic is_upd, input logic [15:0] row,
                                            input logic [15:0] d, input logic [15:0] t,
                                            input logic u);
        return is_upd ? ((row & ~t) | ({16{u}} & t)) : d;
    endfunction

    // Toy subarray: writes land on the chip_enable edge, search result is combinational.
    logic [15:0] sa_cmp [32];
    logic [15:0] sa_ppg [4];
    int ce_pulses = 0;
    assign sub_tag_out = srch(sub_op, sa_cmp[sub_ca[4:0]], sa_ppg[sub_pa[1:0]], sub_cd, sub_pd);

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) sa_cmp[i] <= '0;
            for (int i = 0; i < 4; i++) sa_ppg[i] <= '0;
        end else if (sub_ce && sub_op[2:1] == 2'b00) begin
            if (sub_sel) sa_ppg[sub_pa[1:0]] <= upd_row(sub_op[0], sa_ppg[sub_pa[1:0]],
                                                        sub_data, sub_tag, sub_upd);
            else         sa_cmp[sub_ca[4:0]] <= upd_row(sub_op[0], sa_cmp[sub_ca[4:0]],
                                                        sub_data, sub_tag, sub_upd);
        end
        if (sub_ce) ce_pulses <= ce_pulses + 1;
    end

    // Reference model: per command, the cycle at which the response must appear and its value.
    int          cyc = 0;
    int          drv_k = -1;
    int          m_acc_cnt = 0, m_acc_cyc = 0;
    bit          m_live = 0, m_idle = 1, m_resp = 0, m_ce = 0, m_fresh = 1;
    int          m_e = 0, m_r = 0, m_err_cnt = 0;
    logic [15:0] m_tag = '0, p_tag = '0;
    logic        m_err = 1'b0, p_err = 1'b0;
    logic [54:0] m_sub = '0;
    logic [15:0] m_cmp [32];
    logic [15:0] m_ppg [4];

    task automatic m_enter_resp();
        m_resp = 1;
        m_tag  = p_tag;
        m_err  = p_err;
        if (p_err && m_err_cnt != 255) m_err_cnt++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_live = 1; m_idle = 1; m_resp = 0; m_ce = 0; m_fresh = 1;
                m_err_cnt = 0; m_tag = '0; m_err = 1'b0; m_sub = '0;
                for (int i = 0; i < 32; i++) m_cmp[i] = '0;
                for (int i = 0; i < 4; i++) m_ppg[i] = '0;
            end else begin
                m_ce = 0;
                if (m_idle) begin
                    if (bus.cmd_valid) begin
                        m_acc_cnt++;
                        m_acc_cyc = cyc;
                        m_idle = 0; m_fresh = 0; m_e = 0;
                        m_sub = {bus.cmd_data, bus.cmd_update, bus.cmd_cmp_addr, bus.cmd_ppg_addr,
                                 bus.cmd_cmp_data, bus.cmd_ppg_data, bus.cmd_tag,
                                 bus.cmd_addr_sel, bus.cmd_op};
                        if (bus.cmd_op == 3'b111) begin
                            p_tag = '0; p_err = 1'b1;
                            m_enter_resp();
                        end else if (bus.cmd_op[2:1] == 2'b00) begin
                            m_ce = 1;
                            p_tag = '0;
                            p_err = !(drv_k >= 1 && drv_k <= TO);
                            m_r = 1 + (p_err ? TO : drv_k);
                            if (bus.cmd_addr_sel)
                                m_ppg[bus.cmd_ppg_addr[1:0]] = upd_row(bus.cmd_op[0],
                                    m_ppg[bus.cmd_ppg_addr[1:0]], bus.cmd_data, bus.cmd_tag,
                                    bus.cmd_update);
                            else
                                m_cmp[bus.cmd_cmp_addr[4:0]] = upd_row(bus.cmd_op[0],
                                    m_cmp[bus.cmd_cmp_addr[4:0]], bus.cmd_data, bus.cmd_tag,
                                    bus.cmd_update);
                        end else begin
                            m_ce = 1;
                            m_r = 2;
                            p_err = 1'b0;
                            p_tag = srch(bus.cmd_op, m_cmp[bus.cmd_cmp_addr[4:0]],
                                         m_ppg[bus.cmd_ppg_addr[1:0]], bus.cmd_cmp_data,
                                         bus.cmd_ppg_data);
                        end
                    end
                end else if (m_resp) begin
                    if (bus.rsp_ready) begin
                        m_resp = 0;
                        m_idle = 1;
                    end
                end else begin
                    m_e++;
                    if (m_e == m_r) m_enter_resp();
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("cmd_ready", 64'(bus.cmd_ready), 64'(m_idle));
                chk("busy", 64'(busy), 64'(!m_idle));
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_resp));
                chk("chip_enable", 64'(sub_ce), 64'(m_ce));
                chk("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
                chk("sub_fields", 64'({sub_data, sub_upd, sub_ca, sub_pa, sub_cd, sub_pd,
                                       sub_tag, sub_sel, sub_op}), 64'(m_sub));
                if (m_resp || m_fresh) begin
                    chk("rsp_tag", 64'(bus.rsp_tag), 64'(m_tag));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
                end
            end
        end
    end

    int done_at = -1;
    bit hold_lo = 0, force_hi = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2 sub_write_done = (cyc == done_at);
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #3 bus.rsp_ready = hold_lo ? 1'b0 : (force_hi ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
    end

    function automatic cmd_t mk(input logic [2:0] op, input logic sel, input logic [9:0] ca,
                                input logic [3:0] pa, input logic [1:0] cd, input logic [1:0] pd,
                                input logic [15:0] d, input logic [15:0] t, input logic u);
        cmd_t c;
        c = '{op: op, sel: sel, ca: ca, pa: pa, cd: cd, pd: pd, d: d, t: t, u: u};
        return c;
    endfunction

    // mode 0: wait until idle again, 1: return once rsp_valid seen, 2: return after accept
    task automatic send(input cmd_t c, input int k, input int mode, output int lat,
                        output logic [15:0] tag, output logic err);
        int acc0, n;
        lat = -1; tag = '0; err = 1'b0;
        bus.cmd_op = c.op; bus.cmd_addr_sel = c.sel; bus.cmd_cmp_addr = c.ca;
        bus.cmd_ppg_addr = c.pa; bus.cmd_cmp_data = c.cd; bus.cmd_ppg_data = c.pd;
        bus.cmd_data = c.d; bus.cmd_tag = c.t; bus.cmd_update = c.u;
        drv_k = k;
        bus.cmd_valid = 1'b1;
        acc0 = m_acc_cnt;
        n = 0;
        while (m_acc_cnt == acc0 && n < 40) begin @(posedge clk); #1; n++; end
        bus.cmd_valid = 1'b0;
        if (m_acc_cnt == acc0) begin
            chk("accept_bound", 64'(0), 64'(1));
            return;
        end
        done_at = (k < 0) ? -1 : m_acc_cyc + k;
        if (mode == 2) return;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!bus.rsp_valid) chk("rsp_bound", 64'(0), 64'(1));
        tag = bus.rsp_tag;
        err = bus.rsp_err;
        if (mode == 1) return;
        n = 0;
        while (!m_idle && n < 100) begin @(posedge clk); #1; n++; end
        if (!m_idle) chk("idle_bound", 64'(0), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, ce0, k;
        logic [15:0] tag;
        logic        err;
        cmd_t        c;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr_sel = 1'b0; bus.cmd_cmp_addr = '0;
        bus.cmd_ppg_addr = '0; bus.cmd_cmp_data = '0; bus.cmd_ppg_data = '0; bus.cmd_data = '0;
        bus.cmd_tag = '0; bus.cmd_update = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_err_cnt", 64'(err_cnt), 64'(0));

        // write cmp row 5, then search it
        send(mk(3'b000, 1'b0, 10'd5, 4'd0, 2'b00, 2'b00, 16'hA5A5, 16'h0, 1'b0), 1, 0, lat, tag, err);
        chk("t1_wr_err", 64'(err), 64'(0));
        send(mk(3'b010, 1'b0, 10'd5, 4'd0, 2'b01, 2'b00, 16'h0, 16'h0, 1'b0), -1, 0, lat, tag, err);
        chk("t1_srch_tag", 64'(tag), 64'(16'hA5A5));
        chk("t1_srch_lat", 64'(lat), 64'(2));
        chk("t1_err_cnt", 64'(err_cnt), 64'(0));

        // ppg write, masked update, search
        send(mk(3'b000, 1'b1, 10'd0, 4'd2, 2'b00, 2'b00, 16'h00FF, 16'h0, 1'b0), 2, 0, lat, tag, err);
        send(mk(3'b001, 1'b1, 10'd0, 4'd2, 2'b00, 2'b00, 16'h0, 16'h0F0F, 1'b1), 1, 0, lat, tag, err);
        send(mk(3'b011, 1'b0, 10'd0, 4'd2, 2'b00, 2'b01, 16'h0, 16'h0, 1'b0), -1, 0, lat, tag, err);
        chk("t2_srch_tag", 64'(tag), 64'(16'h0FFF));

        // write_done never arrives
        send(mk(3'b000, 1'b0, 10'd7, 4'd0, 2'b00, 2'b00, 16'h1234, 16'h0, 1'b0), -1, 0, lat, tag, err);
        chk("t3_lat", 64'(lat), 64'(TO + 1));
        chk("t3_err", 64'(err), 64'(1));
        chk("t3_tag", 64'(tag), 64'(0));
        chk("t3_err_cnt", 64'(err_cnt), 64'(1));

        // illegal op
        ce0 = ce_pulses;
        send(mk(3'b111, 1'b0, 10'd0, 4'd0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0), -1, 0, lat, tag, err);
        chk("t4_lat", 64'(lat), 64'(0));
        chk("t4_err", 64'(err), 64'(1));
        chk("t4_no_ce", 64'(ce_pulses), 64'(ce0));
        chk("t4_err_cnt", 64'(err_cnt), 64'(2));

        // response back-pressure
        hold_lo = 1;
        send(mk(3'b010, 1'b0, 10'd5, 4'd0, 2'b01, 2'b00, 16'h0, 16'h0, 1'b0), -1, 1, lat, tag, err);
        repeat (10) begin @(posedge clk); #1; end
        chk("t5_held_valid", 64'(bus.rsp_valid), 64'(1));
        chk("t5_held_tag", 64'(bus.rsp_tag), 64'(16'hA5A5));
        chk("t5_held_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        hold_lo = 0;
        repeat (6) begin @(posedge clk); #1; end

        // reset while waiting for write_done
        send(mk(3'b000, 1'b0, 10'd3, 4'd0, 2'b00, 2'b00, 16'hBEEF, 16'h0, 1'b0), -1, 2, lat, tag, err);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("t6_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("t6_err_cnt", 64'(err_cnt), 64'(0));
        chk("t6_sub_op", 64'(sub_op), 64'(0));
        repeat (4) begin @(posedge clk); #1; end

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            c = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   {5'($urandom), 5'($urandom_range(0, 3))}, 4'($urandom),
                   2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)));
            if (c.op == 3'b111)       k = -1;
            else if (c.op[2:1] == 0)  k = int'($urandom_range(0, TO + 3)) - 1;
            else                      k = int'($urandom_range(0, 3)) - 1;
            send(c, k, int'($urandom_range(0, 1)), lat, tag, err);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        // error counter saturation
        force_hi = 1;
        for (int i = 0; i < 260; i++)
            send(mk(3'b111, 1'b0, 10'd0, 4'd0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0), -1, 0,
                 lat, tag, err);
        chk("sat_err_cnt", 64'(err_cnt), 64'(8'hFF));
        repeat (3) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
